// File: rtl/lcd_frame_scheduler_if.sv
// Bundle between the LCD frame scheduler and its environment (host stream,
// pattern generator, RGB line FIFO, panel sync and control registers).
// master: drives syncs, source bytes, FIFO status and control; observes the rest.
// slave:  the scheduler; drives readies, FIFO write port, frame status and errors.
interface lcd_frame_scheduler_if #(
    parameter int CW = 16
);
    // control
    logic          enable;
    logic          src_sel;
    logic          err_clr;
    // panel timing
    logic          VSYNC;
    logic          HSYNC;
    // host byte stream
    logic          host_valid;
    logic [7:0]    host_data;
    logic          host_ready;
    // test-pattern byte stream
    logic          pat_valid;
    logic [7:0]    pat_data;
    logic          pat_ready;
    // FIFO write port
    logic          fifo_full;
    logic          fifo_we;
    logic [7:0]    fifo_wdata;
    // status
    logic          frame_start;
    logic          frame_done;
    logic          busy;
    logic [CW-1:0] line_cnt;
    logic          err_underrun;
    logic          err_abort;

    modport master (
        output enable, src_sel, err_clr, VSYNC, HSYNC,
        output host_valid, host_data, pat_valid, pat_data, fifo_full,
        input  host_ready, pat_ready, fifo_we, fifo_wdata,
        input  frame_start, frame_done, busy, line_cnt, err_underrun, err_abort
    );

    modport slave (
        input  enable, src_sel, err_clr, VSYNC, HSYNC,
        input  host_valid, host_data, pat_valid, pat_data, fifo_full,
        output host_ready, pat_ready, fifo_we, fifo_wdata,
        output frame_start, frame_done, busy, line_cnt, err_underrun, err_abort
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// Frame/line sequencer muxing host or test-pattern bytes into the RGB line FIFO.
// Latency: accepted byte appears on fifo_we/fifo_wdata one cycle after acceptance.
// Backpressure: readies drop combinationally on fifo_full (almost-full) or enable=0.
// Ports: CLK, nRST (async active-low) plus the slave side of lcd_frame_scheduler_if.
module lcd_frame_scheduler #(
    parameter int BYTES_PER_LINE = 1600,
    parameter int LINES          = 480,
    parameter int CW             = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    lcd_frame_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_LINE,
        XFER,
        LINE_END,
        FRAME_END
    } state_t;

    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_LINE - 1);
    localparam logic [CW-1:0] LAST_LINE = CW'(LINES - 1);

    state_t        state;
    logic          cur_src;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] line_cnt;

    logic          vs_q;
    logic          hs_q;
    logic          vs_fall;
    logic          hs_fall;
    logic          hs_rise;

    logic          fifo_we;
    logic [7:0]    fifo_wdata;
    logic          frame_start;
    logic          frame_done;
    logic          busy;
    logic          err_underrun;
    logic          err_abort;

    logic          xfer_ok;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          acc;
    logic          line_done;
    logic          abort;

    // Edges compare the registered sync against the live input, so they act
    // in the same cycle the input changes.
    assign vs_fall = vs_q & ~bus.VSYNC;
    assign hs_fall = hs_q & ~bus.HSYNC;
    assign hs_rise = ~hs_q & bus.HSYNC;

    // Acceptance is gated by enable so disabling drops ready immediately.
    assign xfer_ok   = bus.enable & (state == XFER) & ~bus.fifo_full;
    assign sel_valid = cur_src ? bus.host_valid : bus.pat_valid;
    assign sel_data  = cur_src ? bus.host_data  : bus.pat_data;
    assign acc       = xfer_ok & sel_valid;
    assign line_done = acc & (byte_cnt == LAST_BYTE);

    // Abort keys off the registered VSYNC so a VSYNC that has already fallen
    // again can abort and restart the frame in the same cycle.
    assign abort = vs_q & ((state == WAIT_LINE) | (state == XFER));

    assign bus.host_ready   = xfer_ok & cur_src;
    assign bus.pat_ready    = xfer_ok & ~cur_src;
    assign bus.fifo_we      = fifo_we;
    assign bus.fifo_wdata   = fifo_wdata;
    assign bus.frame_start  = frame_start;
    assign bus.frame_done   = frame_done;
    assign bus.busy         = busy;
    assign bus.line_cnt     = line_cnt;
    assign bus.err_underrun = err_underrun;
    assign bus.err_abort    = err_abort;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            cur_src      <= 1'b0;
            byte_cnt     <= '0;
            line_cnt     <= '0;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            fifo_we      <= 1'b0;
            fifo_wdata   <= 8'h00;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            vs_q        <= bus.VSYNC;
            hs_q        <= bus.HSYNC;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            // One-entry write pipeline; a byte accepted in an abort or
            // disable cycle still lands in the FIFO next cycle.
            fifo_we <= acc;
            if (acc) begin
                fifo_wdata <= sel_data;
            end

            // Clear first so a same-cycle error set below overrides it.
            if (bus.err_clr) begin
                err_underrun <= 1'b0;
                err_abort    <= 1'b0;
            end

            if (!bus.enable) begin
                state    <= IDLE;
                busy     <= 1'b0;
                byte_cnt <= '0;
                line_cnt <= '0;
            end else if (abort) begin
                err_abort <= 1'b1;
                byte_cnt  <= '0;
                line_cnt  <= '0;
                if (vs_fall) begin
                    cur_src     <= bus.src_sel;
                    frame_start <= 1'b1;
                    state       <= WAIT_LINE;
                    busy        <= 1'b1;
                end else begin
                    state <= WAIT_FRAME;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_FRAME;
                        busy  <= 1'b0;
                    end

                    WAIT_FRAME: begin
                        if (vs_fall) begin
                            cur_src     <= bus.src_sel;
                            line_cnt    <= '0;
                            frame_start <= 1'b1;
                            state       <= WAIT_LINE;
                            busy        <= 1'b1;
                        end
                    end

                    WAIT_LINE: begin
                        if (hs_fall) begin
                            byte_cnt <= '0;
                            state    <= XFER;
                        end
                    end

                    XFER: begin
                        if (acc) begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                        // A last byte coinciding with HSYNC rising still
                        // counts as a complete line.
                        if (line_done) begin
                            state <= LINE_END;
                        end else if (hs_rise) begin
                            err_underrun <= 1'b1;
                            state        <= LINE_END;
                        end
                    end

                    LINE_END: begin
                        if (line_cnt == LAST_LINE) begin
                            frame_done <= 1'b1;
                            state      <= FRAME_END;
                        end else begin
                            line_cnt <= line_cnt + CW'(1);
                            state    <= WAIT_LINE;
                        end
                    end

                    FRAME_END: begin
                        line_cnt <= '0;
                        state    <= WAIT_FRAME;
                        busy     <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Sequences pixel-byte writes into the RGB line FIFO on the CLK domain, one frame at a time, locked to the panel's VSYNC/HSYNC timing.
- Shares the FIFO write port between two requesters: the host stream (i8080 bytes already resynchronised to CLK) and the internal test-pattern generator.
- The source is chosen per frame. Lines are byte-counted, and underrun and abort conditions are flagged for the control-register block.

Parameters:
- BYTES_PER_LINE, 1600, bytes written per line (800 px × 2 bytes RGB565); at least 2.
- LINES, 480, lines per frame; at least 2.
- CW, 16, width of the byte and line counters; must hold max(BYTES_PER_LINE, LINES).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- enable  in  1  scheduler on; when 0, forces IDLE
- src_sel  in  1  0 = pattern, 1 = host; sampled at frame start only
- VSYNC  in  1  vertical sync, active high, synchronous to CLK
- HSYNC  in  1  horizontal sync, active high, synchronous to CLK
- host_valid  in  1  host byte available
- host_data  in  8  host byte
- host_ready  out  1  host byte accepted when host_valid & host_ready
- pat_valid  in  1  pattern byte available
- pat_data  in  8  pattern byte
- pat_ready  out  1  pattern byte accepted when pat_valid & pat_ready
- fifo_full  in  1  FIFO almost-full: fewer than 2 free entries
- fifo_we  out  1  FIFO write strobe, registered
- fifo_wdata  out  8  FIFO write data, registered
- frame_start  out  1  1-cycle pulse when a frame begins
- frame_done  out  1  1-cycle pulse after the last byte of the last line
- busy  out  1  high in any state other than IDLE and WAIT_FRAME
- line_cnt  out  CW  index of the current line
- err_underrun  out  1  sticky: a line ended short
- err_abort  out  1  sticky: VSYNC arrived mid-frame
- err_clr  in  1  clears both sticky error flags

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; cur_src 0.
- Edge detection: VSYNC and HSYNC are registered once. vs_fall = prev & ~cur; hs_fall and hs_rise are formed the same way. These edges act in the cycle they are detected.
- Selected source: cur_src, latched from src_sel at frame start.
- Acceptance (combinational): acc = (state==XFER) & ~fifo_full & sel_valid.
  - host_ready = (state==XFER) & ~fifo_full & cur_src.
  - pat_ready = (state==XFER) & ~fifo_full & ~cur_src.
  - The unselected source's ready is always 0.
- Write latency: on acc, fifo_we = 1 and fifo_wdata = selected data in the next cycle; otherwise fifo_we = 0 and fifo_wdata holds its value. The almost-full margin covers this 1-entry pipeline.
- State machine:
  - IDLE: enable = 1 → WAIT_FRAME.
  - WAIT_FRAME: on vs_fall, latch cur_src, set line_cnt = 0, pulse frame_start → WAIT_LINE.
  - WAIT_LINE: on hs_fall, set byte_cnt = 0 → XFER.
  - XFER: each acc increments byte_cnt. On acc with byte_cnt == BYTES_PER_LINE−1, the line is complete → LINE_END.
  - XFER, HSYNC rising before the line is complete: set err_underrun, go to LINE_END. Bytes not yet written are dropped, not padded.
  - LINE_END (1 cycle): if line_cnt == LINES−1 → FRAME_END; otherwise line_cnt++ → WAIT_LINE.
  - FRAME_END (1 cycle): pulse frame_done, line_cnt = 0 → WAIT_FRAME.
- VSYNC high in WAIT_LINE or XFER: set err_abort, clear counters, go to WAIT_FRAME. No frame_done is issued.
  - A write already in the output register still completes next cycle.
  - If the same cycle is also a vs_fall, the frame restarts as described under WAIT_FRAME.
- enable = 0 in any state: go to IDLE next cycle and drop ready immediately (ready terms are gated by enable). No error flag is raised.
- Simultaneous events:
  - acc on the last byte in the same cycle as hs_rise: the line counts as complete and no underrun is flagged.
  - err_clr in the same cycle as a new error: the set wins.
- Counters never wrap: byte_cnt is frozen outside XFER, and writes stop at BYTES_PER_LINE.
- nRST asserted mid-frame: immediate return to reset values. A pending fifo_we is cleared.

Test Plan:
- Nominal host frame (BYTES_PER_LINE = 4, LINES = 2, src_sel = 1, host_valid held 1, bytes 0x01 upward):
  - frame_start pulses 1 cycle after VSYNC falls.
  - fifo_wdata carries 0x01..0x08, with each fifo_we 1 cycle after acceptance.
  - frame_done pulses once; line_cnt returns to 0.
- Backpressure: hold fifo_full = 1 for 3 cycles mid-line.
  - host_ready = 0 and fifo_we = 0 for those cycles.
  - No byte is lost or duplicated; line completes with 4 writes.
- Source latching: src_sel = 0 at frame start, toggled to 1 mid-frame.
  - Only pat_data bytes are written; host_ready stays 0 the whole frame.
  - The next frame uses the host.
- Underrun: host_valid stays 0 after 2 bytes, then HSYNC rises.
  - err_underrun = 1 and line_cnt advances.
  - err_clr drops the flag the next cycle.
- Abort: VSYNC goes high during line 1 of 2.
  - err_abort = 1, no frame_done, state returns to WAIT_FRAME.
  - The next VSYNC fall starts a clean frame with line_cnt = 0.
- Reset and disable:
  - enable = 0 mid-line → ready low at once, IDLE next cycle.
  - nRST low mid-line → all outputs 0 asynchronously.
